// File: rtl/rf_scoreboard_pkg.sv
// Shared register-file constants and types, used by the RF, hazard unit,
// pipeline registers and the write scoreboard.
package rf_scoreboard_pkg;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 2;
    localparam int TOT_W = 6;

    typedef logic [AW-1:0] regAddr_t;

    localparam regAddr_t REG_ZERO = '0;

    // Number of write-backs (retire and/or kill) landing on one register this cycle.
    function automatic logic [1:0] decCount(input logic retire, input logic kill);
        return {1'b0, retire} + {1'b0, kill};
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// D-stage issue, squash and W-stage write signals seen by the scoreboard,
// plus the hazard indications it returns.
interface rf_scoreboard_if;
    import rf_scoreboard_pkg::*;

    logic             IssueEn;
    regAddr_t         IssueA3;
    logic             KillEn;
    regAddr_t         KillA3;
    logic             RFWr;
    regAddr_t         A3;
    regAddr_t         A1;
    regAddr_t         A2;
    logic             Busy1;
    logic             Busy2;
    logic             Stall;
    logic [TOT_W-1:0] InFlight;
    logic             Err;

    modport master (
        output IssueEn, IssueA3, KillEn, KillA3, RFWr, A3, A1, A2,
        input  Busy1, Busy2, Stall, InFlight, Err
    );

    modport slave (
        input  IssueEn, IssueA3, KillEn, KillA3, RFWr, A3, A1, A2,
        output Busy1, Busy2, Stall, InFlight, Err
    );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// Saturating pending-write counter for one register: +1 on issue, -0..2 on
// retire/kill, clamped to [0, 2^Width-1] with a one-cycle err pulse on clamp.
module sb_counter #(
    parameter int Width = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc_i,
    input  logic [1:0]       decCount_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] next_o,
    output logic             err_o
);

    localparam int SumW = Width + 3;
    localparam logic [SumW-1:0] MaxCnt = SumW'((2 ** Width) - 1);

    logic [Width-1:0] cnt_q, cnt_d;
    logic [SumW-1:0]  sum;

    // Sum is computed wide enough that a negative result shows up in the MSB.
    always_comb begin
        sum   = SumW'(cnt_q) + SumW'(inc_i) - SumW'(decCount_i);
        cnt_d = sum[Width-1:0];
        err_o = 1'b0;
        if (sum[SumW-1]) begin
            cnt_d = '0;
            err_o = 1'b1;
        end else if (sum > MaxCnt) begin
            cnt_d = MaxCnt[Width-1:0];
            err_o = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
    assign next_o  = cnt_d;

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: counts issued-but-not-written destinations
// and flags pending sources. Define SCOREBOARD_WB_BYPASS_EN for an RF with W-to-D forwarding.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    rf_scoreboard_if.slave sb
);

    logic [NREG-1:0][CNT_W-1:0] cnt_q;
    logic [NREG-1:0][CNT_W-1:0] cnt_d;
    logic [NREG-1:0]            errPulse;
    logic [TOT_W-1:0]           inFlight_q, inFlight_d, deltaSum;
    logic                       err_q, err_d;
    logic                       busy1, busy2;

    // Register 0 never holds a pending write, so its slot is tied off.
    assign cnt_q[0]    = '0;
    assign cnt_d[0]    = '0;
    assign errPulse[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : gCnt
        logic       inc;
        logic [1:0] dec;

        assign inc = sb.IssueEn && (sb.IssueA3 == AW'(r));
        assign dec = decCount(sb.RFWr && (sb.A3 == AW'(r)),
                              sb.KillEn && (sb.KillA3 == AW'(r)));

        sb_counter #(.Width(CNT_W)) uCnt (
            .Clk        (Clk),
            .Reset      (Reset),
            .inc_i      (inc),
            .decCount_i (dec),
            .count_o    (cnt_q[r]),
            .next_o     (cnt_d[r]),
            .err_o      (errPulse[r])
        );
    end

    // InFlight follows the clamped per-register changes so it always matches their sum.
    always_comb begin
        deltaSum = '0;
        for (int r = 1; r < NREG; r++) begin
            deltaSum = deltaSum + TOT_W'(cnt_d[r]) - TOT_W'(cnt_q[r]);
        end
        inFlight_d = inFlight_q + deltaSum;
        err_d      = err_q | (|errPulse);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            inFlight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inFlight_q <= inFlight_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        busy1 = (sb.A1 != REG_ZERO) && (cnt_q[sb.A1] != '0);
        busy2 = (sb.A2 != REG_ZERO) && (cnt_q[sb.A2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The last pending write lands this cycle and the RF forwards it to D.
        if (sb.RFWr && (sb.A3 == sb.A1) && (cnt_q[sb.A1] == CNT_W'(1)) &&
            !(sb.IssueEn && (sb.IssueA3 == sb.A1)))
            busy1 = 1'b0;
        if (sb.RFWr && (sb.A3 == sb.A2) && (cnt_q[sb.A2] == CNT_W'(1)) &&
            !(sb.IssueEn && (sb.IssueA3 == sb.A2)))
            busy2 = 1'b0;
`endif
    end

    assign sb.Busy1    = busy1;
    assign sb.Busy2    = busy2;
    assign sb.Stall    = busy1 | busy2;
    assign sb.InFlight = inFlight_q;
    assign sb.Err      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed and random checks of rf_scoreboard against a per-register count
// model; honours SCOREBOARD_WB_BYPASS_EN when defined.
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    rf_scoreboard_if sbIf();

    rf_scoreboard dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sb    (sbIf)
    );

    int checks = 0;
    int errors = 0;

    localparam int MaxCnt = (1 << CNT_W) - 1;

    int mCnt[NREG];
    int mErr;

    bit sRst, sIe, sKe, sRw;
    int sIa, sKa, sWa, sA1, sA2;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int modelInFlight();
        int s = 0;
        for (int r = 0; r < NREG; r++) s += mCnt[r];
        return s % (1 << TOT_W);
    endfunction

    function automatic bit modelBusy(input int a);
        bit b = (a != 0) && (mCnt[a] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (sRw && sWa == a && mCnt[a] == 1 && !(sIe && sIa == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic modelClear();
        for (int r = 0; r < NREG; r++) mCnt[r] = 0;
        mErr = 0;
    endtask

    // Net effect of one clock edge on the pending-write counts.
    task automatic modelStep();
        int d[NREG];
        int n;
        if (sRst) begin
            modelClear();
            return;
        end
        for (int r = 0; r < NREG; r++) d[r] = 0;
        if (sIe && sIa != 0) d[sIa] += 1;
        if (sRw && sWa != 0) d[sWa] -= 1;
        if (sKe && sKa != 0) d[sKa] -= 1;
        for (int r = 1; r < NREG; r++) begin
            n = mCnt[r] + d[r];
            if (n > MaxCnt) begin n = MaxCnt; mErr = 1; end
            else if (n < 0) begin n = 0; mErr = 1; end
            mCnt[r] = n;
        end
    endtask

    task automatic checkOutput(input string tag);
        bit b1, b2;
        b1 = modelBusy(sA1);
        b2 = modelBusy(sA2);
        checkVal({tag, ".busy1"}, 32'(sbIf.Busy1), 32'(b1));
        checkVal({tag, ".busy2"}, 32'(sbIf.Busy2), 32'(b2));
        checkVal({tag, ".stall"}, 32'(sbIf.Stall), 32'(b1 | b2));
        checkVal({tag, ".inflight"}, 32'(sbIf.InFlight), 32'(modelInFlight()));
        checkVal({tag, ".err"}, 32'(sbIf.Err), 32'(mErr));
    endtask

    task automatic applyStimulus(input bit rst, input bit ie, input int ia,
                                 input bit ke, input int ka, input bit rw, input int wa,
                                 input int a1, input int a2, input string tag);
        sRst = rst; sIe = ie; sIa = ia; sKe = ke; sKa = ka;
        sRw = rw; sWa = wa; sA1 = a1; sA2 = a2;
        Reset        = rst;
        sbIf.IssueEn = ie;
        sbIf.IssueA3 = AW'(ia);
        sbIf.KillEn  = ke;
        sbIf.KillA3  = AW'(ka);
        sbIf.RFWr    = rw;
        sbIf.A3      = AW'(wa);
        sbIf.A1      = AW'(a1);
        sbIf.A2      = AW'(a2);
        #1;
        checkOutput(tag);
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    initial begin
        Reset        = 1'b1;
        sbIf.IssueEn = 1'b0; sbIf.IssueA3 = '0;
        sbIf.KillEn  = 1'b0; sbIf.KillA3  = '0;
        sbIf.RFWr    = 1'b0; sbIf.A3      = '0;
        sbIf.A1      = '0;   sbIf.A2      = '0;
        @(posedge Clk);
        #1;
        modelClear();

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        checkVal("rst.inflight0", 32'(sbIf.InFlight), 32'd0);

        // Events addressed to register 0 are ignored.
        applyStimulus(0, 1, 0, 1, 0, 1, 0, 0, 0, "zero");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "zero2");
        checkVal("zero.err0", 32'(sbIf.Err), 32'd0);
        checkVal("zero.busy1", 32'(sbIf.Busy1), 32'd0);

        applyStimulus(0, 1, 8, 0, 0, 0, 0, 8, 0, "iss8");
        checkVal("iss8.inflight1", 32'(sbIf.InFlight), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 8, 8, 0, "wb8");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 0, "post8");
        checkVal("post8.inflight0", 32'(sbIf.InFlight), 32'd0);

        applyStimulus(0, 1, 9, 0, 0, 0, 0, 9, 0, "iss9");
        applyStimulus(0, 1, 9, 0, 0, 1, 9, 9, 0, "isswb9");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 0, "hold9");
        checkVal("hold9.inflight1", 32'(sbIf.InFlight), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 9, 0, "wb9");

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 5, "iss5");
        checkVal("sat5.err1", 32'(sbIf.Err), 32'd1);
        checkVal("sat5.inflight3", 32'(sbIf.InFlight), 32'd3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 5, "wb5");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, "post5");
        checkVal("post5.busy2", 32'(sbIf.Busy2), 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst2");
        applyStimulus(0, 1, 12, 0, 0, 0, 0, 12, 0, "iss12");
        applyStimulus(0, 0, 0, 1, 12, 0, 0, 12, 0, "kill12");
        applyStimulus(0, 0, 0, 0, 0, 1, 12, 12, 0, "wb12");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12, 0, "post12");
        checkVal("post12.err1", 32'(sbIf.Err), 32'd1);

        applyStimulus(0, 1, 3, 0, 0, 0, 0, 3, 4, "iss3");
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 3, 4, "iss4");
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 3, 4, "rst3");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 3, "post7");
        checkVal("rst3.err0", 32'(sbIf.Err), 32'd0);
        checkVal("rst3.inflight0", 32'(sbIf.InFlight), 32'd0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 50, $urandom_range(0, 7),
                          $urandom_range(0, 99) < 15, $urandom_range(0, 7),
                          $urandom_range(0, 99) < 35, $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
